bram_arbiter: RTL and testbench
===============================

Name: bram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port bram.
- Port 0 is typically the instruction fetch; port 1 is the data load/store path.
- Serializes accesses, drives the bram read/write strobes for exactly one cycle, waits for bram done, and routes the response back to the owning requester.
- Sits between the core memory interfaces and the bram instance inside the SoC memory subsystem.

Parameters:
- ADDR_W, 32, width of request and bram address.
- DATA_W, 32, width of write/read data.
- TIMEOUT_CYC, 16, cycles to wait for mem_done before error (only used with the optional feature).

Ports:
- clk  in  1  system clock; all logic on posedge.
- res_n  in  1  synchronous active-low reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_write  in  2  per-requester 1=write, 0=read.
- req_addr  in  2*ADDR_W  per-requester byte address; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  2*DATA_W  per-requester write data, packed as above.
- req_ready  out  2  request accepted this cycle when valid&ready.
- resp_valid  out  2  one-cycle response pulse for requester i.
- resp_rdata  out  DATA_W  read data; valid with resp_valid; shared by both requesters.
- resp_err  out  1  timeout flag, qualified by resp_valid; constant 0 without the optional feature.
- mem_addr  out  ADDR_W  to bram addr.
- mem_wdata  out  DATA_W  to bram wdata.
- mem_read  out  1  to bram read.
- mem_write  out  1  to bram write.
- mem_rdata  in  DATA_W  from bram rdata.
- mem_done  in  1  from bram done.

Behaviour:
- Reset values: state=IDLE, last_grant=1, all outputs 0.
- Reset mid-operation: the pending transaction is dropped and no resp_valid is issued. The bram shares res_n and also clears.
- FSM states are IDLE, ISSUE and WAIT.
- IDLE, grant selection (combinational):
  - Only one requester valid: grant that requester.
  - Both valid: grant = ~last_grant.
  - req_ready[grant] = 1 in IDLE when at least one requester is valid. req_ready is never asserted outside IDLE.
- IDLE, on accept:
  - Latch addr, wdata, write and grant index.
  - Update last_grant to the granted index.
  - Go to ISSUE.
- ISSUE:
  - mem_read or mem_write (exclusive, per the latched write bit) is high for exactly this cycle.
  - mem_addr and mem_wdata are held from ISSUE through WAIT; they may be zero in IDLE.
  - Next state is WAIT.
- WAIT:
  - Strobes are low.
  - On mem_done=1: resp_valid[grant]=1 on the next cycle (registered), resp_rdata=mem_rdata for reads and 0 for writes. Return to IDLE.
  - Otherwise stay in WAIT.
- Latency: accept at T, strobe at T+1, bram done at T+2, resp_valid at T+3. The next accept is possible at T+3, giving back-to-back throughput of 1 access per 3 cycles.
- A mem_done received outside WAIT is ignored.
- Requesters must hold req_* stable while valid and not ready. The arbiter does not buffer more than one transaction.
- The same requester continuously valid alone is granted every opportunity; there is no starvation of the other requester once it asserts valid.

Optional Feature:
- Macro: BRAM_ARB_TIMEOUT_EN.
- When defined:
  - A counter runs in WAIT.
  - If TIMEOUT_CYC cycles elapse without mem_done: resp_valid[grant]=1 with resp_err=1 and resp_rdata=0, then return to IDLE.
  - The counter clears on entry to WAIT.
- When undefined:
  - No counter is present and WAIT lasts indefinitely.
  - resp_err is tied to 0.

Test Plan:
- Reset held 3 cycles with both req_valid high -> req_ready=0, resp_valid=0, mem_read=mem_write=0. After release, requester 0 is accepted first.
- Requester 1 writes addr 0x10, data 0xDEADBEEF, then reads 0x10 -> mem_write is a single-cycle pulse with mem_addr=0x10. Read response resp_rdata=0xDEADBEEF with resp_valid[1] at accept+3.
- Both requesters continuously valid for 4 transactions -> grants alternate 0,1,0,1 and each resp_valid goes to the matching bit only.
- res_n deasserted during WAIT -> no resp_valid. After reset, a new request completes normally with the 3-cycle latency.
- With BRAM_ARB_TIMEOUT_EN and TIMEOUT_CYC=4, bram model never asserts done -> resp_valid with resp_err=1 exactly 4 cycles after WAIT entry; the FSM returns to IDLE.

Source files
------------

// File: rtl/bram_arbiter.sv
// ---------------------------------------------------------------------------
// bram_arbiter
//
// Two-requester round-robin arbiter and sequencer in front of a single-port
// bram. Requester 0 is normally instruction fetch, requester 1 the data
// load/store path. One transaction is in flight at a time: the request is
// latched on accept, the bram strobe is driven for exactly one cycle, the
// arbiter waits for mem_done and returns a registered one-cycle response to
// the requester that owns the transaction.
//
// Timing: accept at T, strobe at T+1, mem_done at T+2, resp_valid at T+3.
// The next accept can happen at T+3 (1 access per 3 cycles).
//
// Optional build macro:
//   BRAM_ARB_TIMEOUT_EN  - when defined, WAIT gives up after TIMEOUT_CYC
//                          cycles without mem_done and answers with
//                          resp_err=1, resp_rdata=0. When undefined, WAIT
//                          lasts until mem_done and resp_err is tied to 0.
//
// Ports:
//   clk         in   system clock, all logic on posedge
//   res_n       in   synchronous active-low reset
//   req_valid   in   [1:0]  request valid, bit i = requester i
//   req_write   in   [1:0]  1 = write, 0 = read
//   req_addr    in   [2*ADDR_W-1:0]  requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata   in   [2*DATA_W-1:0]  requester i at [i*DATA_W +: DATA_W]
//   req_ready   out  [1:0]  request accepted when valid & ready
//   resp_valid  out  [1:0]  one-cycle response pulse per requester
//   resp_rdata  out  [DATA_W-1:0]  read data, 0 for writes and timeouts
//   resp_err    out  timeout flag, qualified by resp_valid
//   mem_addr    out  [ADDR_W-1:0]  bram address, held ISSUE..WAIT
//   mem_wdata   out  [DATA_W-1:0]  bram write data, held ISSUE..WAIT
//   mem_read    out  bram read strobe (one cycle)
//   mem_write   out  bram write strobe (one cycle)
//   mem_rdata   in   [DATA_W-1:0]  bram read data
//   mem_done    in   bram completion
// ---------------------------------------------------------------------------
module bram_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                res_n,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_write,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          req_ready,
    output logic [1:0]          resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_read,
    output logic                mem_write,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_done
);

    // state | meaning
    // ------+-------------------------------------------------------------
    // IDLE  | no transaction; grant offered to a valid requester
    // ISSUE | one-cycle bram read or write strobe
    // WAIT  | waiting for mem_done (or timeout when enabled)
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("bram_arbiter: TIMEOUT_CYC must be at least 1");
    end

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_last_grant;
    logic                r_grant;
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [1:0]          r_resp_valid;
    logic [DATA_W-1:0]   r_resp_rdata;

    logic                w_sel;
    logic                w_accept;
    logic                w_mem_read;
    logic                w_mem_write;
    logic                w_finish;
    logic                w_timeout;
    logic                w_to_expire;

    // -----------------------------------------------------------------------
    // Grant selection. With a single requester valid it wins outright; with
    // both valid the one that was not served last wins. Ready is gated by
    // res_n so nothing is offered while reset is being held.
    // -----------------------------------------------------------------------
    always_comb begin
        w_sel = 1'b0;
        if (&req_valid) begin
            w_sel = ~r_last_grant;
        end else begin
            w_sel = req_valid[1];
        end
    end

    assign w_accept  = (r_state == IDLE) && res_n && (|req_valid);
    assign req_ready = w_accept ? (w_sel ? 2'b10 : 2'b01) : 2'b00;

    // -----------------------------------------------------------------------
    // Optional WAIT timeout: a down-counter loaded during ISSUE, so every
    // entry into WAIT starts from a full count. Terminal count 0 in WAIT
    // means TIMEOUT_CYC WAIT cycles have passed without mem_done.
    // -----------------------------------------------------------------------
`ifdef BRAM_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TO_W-1:0] r_to_cnt;
    logic            r_resp_err;

    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_to_cnt <= '0;
        end else if (r_state == ISSUE) begin
            r_to_cnt <= TO_W'(TIMEOUT_CYC - 1);
        end else if ((r_state == WAIT) && (r_to_cnt != '0)) begin
            r_to_cnt <= r_to_cnt - 1'b1;
        end
    end

    assign w_to_expire = (r_to_cnt == '0);
`else
    assign w_to_expire = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and strobes
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_finish    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_mem_read  = ~r_write;
                w_mem_write = r_write;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                // mem_done wins over a timeout landing in the same cycle.
                if (mem_done) begin
                    w_finish    = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_to_expire) begin
                    w_finish    = 1'b1;
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: request latch, round-robin history and registered response.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_resp_valid <= 2'b00;
            r_resp_rdata <= '0;
        end else begin
            r_resp_valid <= 2'b00;
            if (w_accept) begin
                r_grant      <= w_sel;
                r_last_grant <= w_sel;
                r_write      <= w_sel ? req_write[1] : req_write[0];
                r_addr       <= w_sel ? req_addr[2*ADDR_W-1:ADDR_W]
                                      : req_addr[ADDR_W-1:0];
                r_wdata      <= w_sel ? req_wdata[2*DATA_W-1:DATA_W]
                                      : req_wdata[DATA_W-1:0];
            end
            if (w_finish) begin
                r_resp_valid <= r_grant ? 2'b10 : 2'b01;
                r_resp_rdata <= (r_write || w_timeout) ? '0 : mem_rdata;
            end
        end
    end

`ifdef BRAM_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_resp_err <= 1'b0;
        end else if (w_finish) begin
            r_resp_err <= w_timeout;
        end
    end

    assign resp_err = r_resp_err;
`else
    assign resp_err = 1'b0;
`endif

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign mem_read   = w_mem_read;
    assign mem_write  = w_mem_write;

endmodule

// File: tb/tb_bram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_arbiter
//
// Directed bench for bram_arbiter with a small behavioural bram: 16 words
// indexed by addr[5:2], done one cycle after a strobe, cleared by res_n.
// bram_hang suppresses done; tb_force_done injects a stray done pulse.
// Inputs change 1 time unit after posedge, outputs are sampled on negedge.
// ---------------------------------------------------------------------------
module tb_bram_arbiter;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int TIMEOUT_CYC = 4;

    logic                clk;
    logic                res_n;
    logic [1:0]          req_valid;
    logic [1:0]          req_write;
    logic [ADDR_W-1:0]   addr0, addr1;
    logic [DATA_W-1:0]   wdata0, wdata1;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          req_ready;
    logic [1:0]          resp_valid;
    logic [DATA_W-1:0]   resp_rdata;
    logic                resp_err;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_read;
    logic                mem_write;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_done;

    logic                bram_done;
    logic                bram_hang;
    logic                tb_force_done;
    logic [DATA_W-1:0]   bram_mem [16];

    int checks;
    int errors;

    assign req_addr  = {addr1, addr0};
    assign req_wdata = {wdata1, wdata0};
    assign mem_done  = bram_done | tb_force_done;

    bram_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .res_n      (res_n),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata),
        .mem_done   (mem_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (!res_n) begin
            bram_done <= 1'b0;
            mem_rdata <= '0;
            for (int i = 0; i < 16; i++) bram_mem[i] <= '0;
        end else begin
            bram_done <= 1'b0;
            if (mem_write && !bram_hang) begin
                bram_mem[mem_addr[5:2]] <= mem_wdata;
                bram_done               <= 1'b1;
            end
            if (mem_read && !bram_hang) begin
                mem_rdata <= bram_mem[mem_addr[5:2]];
                bram_done <= 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        res_n     = 1'b0;
        req_valid = 2'b11;
        req_write = 2'b00;
        addr0     = 32'h4;
        addr1     = 32'h10;
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 2'b00 || resp_valid !== 2'b00 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc %0d: ready=%b resp_valid=%b rd=%b wr=%b, expected all 0",
                         i, req_ready, resp_valid, mem_read, mem_write);
            end
            step();
        end
        res_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL reset_first_grant: req_ready=%b expected 01", req_ready);
        end
        step();
        req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_issue_strobe: rd=%b wr=%b expected rd=1 wr=0", mem_read, mem_write);
        end
        checks++;
        if (mem_addr !== 32'h4) begin
            errors++;
            $display("FAIL reset_issue_addr: mem_addr=%h expected 00000004", mem_addr);
        end
        step();
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobe_one_cycle: mem_read=%b expected 0 in WAIT", mem_read);
        end
        step();
        @(negedge clk);
        checks++;
        if (resp_valid !== 2'b01 || resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_first_resp: resp_valid=%b rdata=%h expected 01 / 00000000", resp_valid, resp_rdata);
        end
    endtask

    task automatic test_write_read();
        step();
        req_valid = 2'b10;
        req_write = 2'b10;
        addr1     = 32'h10;
        wdata1    = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL wr_ready: req_ready=%b expected 10", req_ready);
        end
        step();
        req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_issue: wr=%b rd=%b addr=%h wdata=%h expected 1 0 00000010 deadbeef",
                     mem_write, mem_read, mem_addr, mem_wdata);
        end
        step();
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b0) begin
            errors++;
            $display("FAIL wr_pulse_width: mem_write=%b expected 0 in WAIT", mem_write);
        end
        step();
        @(negedge clk);
        checks++;
        if (resp_valid !== 2'b10 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL wr_resp: resp_valid=%b rdata=%h err=%b expected 10 00000000 0",
                     resp_valid, resp_rdata, resp_err);
        end
        step();
        req_valid = 2'b10;
        req_write = 2'b00;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL rd_ready: req_ready=%b expected 10", req_ready);
        end
        step();
        req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 32'h10) begin
            errors++;
            $display("FAIL rd_issue: rd=%b addr=%h expected 1 00000010", mem_read, mem_addr);
        end
        step();
        @(negedge clk);
        checks++;
        if (resp_valid !== 2'b00) begin
            errors++;
            $display("FAIL rd_resp_early: resp_valid=%b expected 00 at accept+2", resp_valid);
        end
        step();
        @(negedge clk);
        checks++;
        if (resp_valid !== 2'b10 || resp_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rd_resp: resp_valid=%b rdata=%h expected 10 deadbeef", resp_valid, resp_rdata);
        end
    endtask

    task automatic test_alternate();
        logic [1:0]        exp_ready [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [1:0]        exp_strb  [4] = '{2'b10, 2'b01, 2'b01, 2'b10};
        logic [ADDR_W-1:0] exp_addr  [4] = '{32'h4, 32'h10, 32'h4, 32'h10};
        logic [DATA_W-1:0] exp_rd    [4] = '{32'h0, 32'hDEADBEEF, 32'h11112222, 32'h0};
        step();
        req_valid = 2'b11;
        req_write = 2'b01;
        addr0     = 32'h4;
        wdata0    = 32'h11112222;
        addr1     = 32'h10;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if (resp_valid !== exp_ready[k-1] || resp_rdata !== exp_rd[k-1]) begin
                    errors++;
                    $display("FAIL alt_resp %0d: resp_valid=%b rdata=%h expected %b %h",
                             k - 1, resp_valid, resp_rdata, exp_ready[k-1], exp_rd[k-1]);
                end
            end
            checks++;
            if (req_ready !== exp_ready[k]) begin
                errors++;
                $display("FAIL alt_grant %0d: req_ready=%b expected %b", k, req_ready, exp_ready[k]);
            end
            step();
            case (k)
                0: req_write[0] = 1'b0;
                1: begin
                    req_write[1] = 1'b1;
                    wdata1       = 32'hCAFEF00D;
                end
                2: req_valid[0] = 1'b0;
                default: req_valid[1] = 1'b0;
            endcase
            @(negedge clk);
            checks++;
            if ({mem_write, mem_read} !== exp_strb[k] || mem_addr !== exp_addr[k] || req_ready !== 2'b00) begin
                errors++;
                $display("FAIL alt_issue %0d: wr_rd=%b addr=%h ready=%b expected %b %h 00",
                         k, {mem_write, mem_read}, mem_addr, req_ready, exp_strb[k], exp_addr[k]);
            end
            step();
            @(negedge clk);
            checks++;
            if (req_ready !== 2'b00) begin
                errors++;
                $display("FAIL alt_wait_ready %0d: req_ready=%b expected 00", k, req_ready);
            end
            step();
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 2'b10 || resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL alt_resp 3: resp_valid=%b rdata=%h expected 10 00000000", resp_valid, resp_rdata);
        end
    endtask

    task automatic test_reset_mid();
        step();
        req_valid = 2'b01;
        req_write = 2'b00;
        addr0     = 32'h4;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL mid_ready: req_ready=%b expected 01", req_ready);
        end
        step();
        req_valid = 2'b00;
        step();
        res_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clk);
            checks++;
            if (resp_valid !== 2'b00 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_no_resp %0d: resp_valid=%b rd=%b wr=%b expected 00 0 0",
                         i, resp_valid, mem_read, mem_write);
            end
        end
        step();
        res_n     = 1'b1;
        req_valid = 2'b10;
        req_write = 2'b10;
        addr1     = 32'h8;
        wdata1    = 32'h5A5A5A5A;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL mid_after_ready: req_ready=%b expected 10", req_ready);
        end
        step();
        req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b1 || mem_addr !== 32'h8) begin
            errors++;
            $display("FAIL mid_after_issue: wr=%b addr=%h expected 1 00000008", mem_write, mem_addr);
        end
        step();
        @(negedge clk);
        checks++;
        if (resp_valid !== 2'b00) begin
            errors++;
            $display("FAIL mid_after_early: resp_valid=%b expected 00", resp_valid);
        end
        step();
        @(negedge clk);
        checks++;
        if (resp_valid !== 2'b10) begin
            errors++;
            $display("FAIL mid_after_resp: resp_valid=%b expected 10", resp_valid);
        end
        step();
        req_valid = 2'b01;
        req_write = 2'b00;
        addr0     = 32'h8;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL mid_readback_ready: req_ready=%b expected 01", req_ready);
        end
        step();
        req_valid = 2'b00;
        step();
        step();
        @(negedge clk);
        checks++;
        if (resp_valid !== 2'b01 || resp_rdata !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL mid_readback: resp_valid=%b rdata=%h expected 01 5a5a5a5a", resp_valid, resp_rdata);
        end
    endtask

    task automatic test_done_ignored();
        step();
        tb_force_done = 1'b1;
        step();
        tb_force_done = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid !== 2'b00) begin
            errors++;
            $display("FAIL stray_done_idle: resp_valid=%b expected 00", resp_valid);
        end
        step();
        req_valid = 2'b01;
        req_write = 2'b00;
        addr0     = 32'h8;
        step();
        req_valid     = 2'b00;
        tb_force_done = 1'b1;
        step();
        tb_force_done = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid !== 2'b00) begin
            errors++;
            $display("FAIL stray_done_issue: resp_valid=%b expected 00 at accept+2", resp_valid);
        end
        step();
        @(negedge clk);
        checks++;
        if (resp_valid !== 2'b01 || resp_rdata !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL stray_done_resp: resp_valid=%b rdata=%h expected 01 5a5a5a5a", resp_valid, resp_rdata);
        end
    endtask

`ifndef BRAM_ARB_TIMEOUT_EN
    task automatic test_wait_hold();
        step();
        bram_hang = 1'b1;
        req_valid = 2'b01;
        req_write = 2'b00;
        addr0     = 32'h8;
        addr1     = 32'h8;
        step();
        req_valid = 2'b10;
        for (int i = 0; i < 6; i++) begin
            step();
            @(negedge clk);
            checks++;
            if (resp_valid !== 2'b00 || req_ready !== 2'b00) begin
                errors++;
                $display("FAIL hold_wait %0d: resp_valid=%b ready=%b expected 00 00", i, resp_valid, req_ready);
            end
        end
        step();
        bram_hang     = 1'b0;
        tb_force_done = 1'b1;
        step();
        tb_force_done = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid !== 2'b01 || resp_rdata !== 32'h5A5A5A5A || req_ready !== 2'b10) begin
            errors++;
            $display("FAIL hold_release: resp_valid=%b rdata=%h ready=%b expected 01 5a5a5a5a 10",
                     resp_valid, resp_rdata, req_ready);
        end
        step();
        req_valid = 2'b00;
        step();
        step();
        @(negedge clk);
        checks++;
        if (resp_valid !== 2'b10 || resp_rdata !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL hold_waiter_served: resp_valid=%b rdata=%h expected 10 5a5a5a5a", resp_valid, resp_rdata);
        end
    endtask
`else
    task automatic test_timeout();
        step();
        bram_hang = 1'b1;
        req_valid = 2'b10;
        req_write = 2'b00;
        addr1     = 32'h8;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL to_ready: req_ready=%b expected 10", req_ready);
        end
        step();
        req_valid = 2'b00;
        step();
        for (int i = 0; i < TIMEOUT_CYC; i++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 2'b00) begin
                errors++;
                $display("FAIL to_early %0d: resp_valid=%b expected 00", i, resp_valid);
            end
            step();
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 2'b10 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL to_resp: resp_valid=%b err=%b rdata=%h expected 10 1 00000000",
                     resp_valid, resp_err, resp_rdata);
        end
        step();
        bram_hang = 1'b0;
        req_valid = 2'b01;
        addr0     = 32'h8;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL to_back_idle: req_ready=%b expected 01", req_ready);
        end
        step();
        req_valid = 2'b00;
        step();
        step();
        @(negedge clk);
        checks++;
        if (resp_valid !== 2'b01 || resp_err !== 1'b0 || resp_rdata !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL to_recover: resp_valid=%b err=%b rdata=%h expected 01 0 5a5a5a5a",
                     resp_valid, resp_err, resp_rdata);
        end
    endtask
`endif

    initial begin
        checks        = 0;
        errors        = 0;
        res_n         = 1'b0;
        req_valid     = 2'b00;
        req_write     = 2'b00;
        addr0         = '0;
        addr1         = '0;
        wdata0        = '0;
        wdata1        = '0;
        bram_hang     = 1'b0;
        tb_force_done = 1'b0;

        test_reset();
        test_write_read();
        test_alternate();
        test_reset_mid();
        test_done_ignored();
`ifndef BRAM_ARB_TIMEOUT_EN
        test_wait_hold();
`else
        test_timeout();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
